// File: rtl/jtroc_snd_pkg.sv
// ============================================================================
// Module : jtroc_snd_pkg
// Brief  : Shared constants for the sound-command block: FSM encoding and
//          status-port bit positions.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtroc_snd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PEND = 2'd1;
  localparam state_t ST_ACKD = 2'd2;

  localparam int STAT_SNDON_BIT = 0;
  localparam int STAT_PEND_BIT  = 1;
  localparam int STAT_OVR_BIT   = 2;

endpackage

`default_nettype wire

// File: rtl/jtroc_snd_timer.sv
// ============================================================================
// Module : jtroc_snd_timer
// Brief  : Free-running prescaler plus 4-bit timer for the sound CPU timer port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtroc_snd_timer #(
  parameter int PRESC_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tmr_cen,
  output logic [3:0] timer
);

  logic [PRESC_W-1:0] r_presc;
  logic [3:0]         r_timer;
  logic               w_presc_wrap;

  assign w_presc_wrap = tmr_cen & (&r_presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_timer <= 4'd0;
    end else begin
      if (tmr_cen)      r_presc <= r_presc + 1'b1;
      if (w_presc_wrap) r_timer <= r_timer + 4'd1;
    end
  end

  assign timer = r_timer;

endmodule

`default_nettype wire

// File: rtl/jtroc_snd_cmd.sv
// ============================================================================
// Module : jtroc_snd_cmd
// Brief  : Main-to-sound CPU command latch with IRQ handshake, overrun flag
//          and a prescaled timer port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtroc_snd_cmd
  import jtroc_snd_pkg::*;
#(
  parameter int PRESC_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] main_latch,
  input  logic       main_snd_on,
  input  logic       snd_cen,
  input  logic       tmr_cen,
  input  logic       int_ack,
  input  logic       cmd_rd,
  input  logic       stat_rd,
  output logic       snd_irq_n,
  output logic [7:0] cmd_dout,
  output logic [7:0] tmr_dout,
  output logic [7:0] stat_dout
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_snd_on;
  logic       w_edge;
  logic       w_ack;
  logic [7:0] r_cmd;
  logic       r_overrun;
  logic       w_overrun_nxt;
  logic       r_irq_n;
  logic       w_irq_n_nxt;
  logic [7:0] r_stat;
  logic [7:0] w_stat_nxt;
  logic [3:0] w_timer;

  // The command port is a plain read of the held byte; the strobe has no side effect.
  logic w_unused_cmd_rd;
  assign w_unused_cmd_rd = cmd_rd;

  assign w_edge = main_snd_on & ~r_snd_on;
  assign w_ack  = snd_cen & int_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_snd_on  <= 1'b0;
      r_cmd     <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_snd_on  <= main_snd_on;
      r_overrun <= w_overrun_nxt;
      if (w_edge) r_cmd <= main_latch;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_edge) w_state_nxt = ST_PEND;
      ST_PEND: if (w_ack)  w_state_nxt = ST_ACKD;
      ST_ACKD: begin
        if (w_edge)         w_state_nxt = ST_PEND;
        else if (!r_snd_on) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    // A new edge while the previous command is still pending marks a lost command.
    w_overrun_nxt = r_overrun;
    if (r_state == ST_PEND && w_edge) w_overrun_nxt = 1'b1;
    else if (snd_cen && stat_rd)      w_overrun_nxt = 1'b0;

    w_irq_n_nxt                = (w_state_nxt != ST_PEND);
    w_stat_nxt                 = 8'h00;
    w_stat_nxt[STAT_SNDON_BIT] = main_snd_on;
    w_stat_nxt[STAT_PEND_BIT]  = (w_state_nxt == ST_PEND);
    w_stat_nxt[STAT_OVR_BIT]   = w_overrun_nxt;
  end

  // Output flops track the next-state values so they mirror the live registers exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_n <= 1'b1;
      r_stat  <= 8'h00;
    end else begin
      r_irq_n <= w_irq_n_nxt;
      r_stat  <= w_stat_nxt;
    end
  end

  jtroc_snd_timer #(
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .tmr_cen (tmr_cen),
    .timer   (w_timer)
  );

  assign snd_irq_n = r_irq_n;
  assign cmd_dout  = r_cmd;
  assign stat_dout = r_stat;
  assign tmr_dout  = {4'b0000, w_timer};

endmodule

`default_nettype wire

// File: doc/jtroc_snd_cmd.md
JTROC_SND_CMD -- requirements
Module: jtroc_snd_cmd

Interface
REQ-001 SHALL have a parameter PRESC_W, default 10, giving the timer prescaler width in bits.
REQ-002 SHALL have port clk, input, 1 bit: system clock, 24 MHz.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port main_latch, input, 8 bits: command byte from the main CPU sound latch.
REQ-005 SHALL have port main_snd_on, input, 1 bit: main CPU sound-trigger bit. Its rising edge requests a sound IRQ.
REQ-006 SHALL have port snd_cen, input, 1 bit: sound CPU clock enable.
REQ-007 SHALL have port tmr_cen, input, 1 bit: timer base clock enable.
REQ-008 SHALL have port int_ack, input, 1 bit: sound CPU interrupt-acknowledge cycle (M1 and IORQ). Active high; sampled on snd_cen.
REQ-009 SHALL have port cmd_rd, input, 1 bit: sound CPU read strobe for the command port. Sampled on snd_cen.
REQ-010 SHALL have port stat_rd, input, 1 bit: sound CPU read strobe for the status port. Sampled on snd_cen.
REQ-011 SHALL have port snd_irq_n, output, 1 bit: interrupt to the sound CPU, active low.
REQ-012 SHALL have port cmd_dout, output, 8 bits: held command byte.
REQ-013 SHALL have port tmr_dout, output, 8 bits: {4'b0, timer[3:0]}.
REQ-014 SHALL have port stat_dout, output, 8 bits: {5'b0, overrun, pending, main_snd_on}.

Function
REQ-015 SHALL register main_snd_on once and detect a rising edge when the current value is 1 and the registered value is 0.
REQ-016 SHALL load cmd_reg from main_latch in the same clk cycle as a rising edge, regardless of the FSM state.
REQ-017 SHALL hold cmd_dout at cmd_reg at all other times; reading the command port does not change it.
REQ-018 SHALL use a three-state FSM: IDLE, PEND, ACKD.
REQ-019 SHALL move IDLE -> PEND on a rising edge.
REQ-020 SHALL move PEND -> ACKD when snd_cen and int_ack are both high.
REQ-021 SHALL move ACKD -> IDLE when the registered main_snd_on is 0.
REQ-022 SHALL move ACKD -> PEND on a rising edge, which takes priority over the ACKD -> IDLE transition.
REQ-023 SHALL drive snd_irq_n = 0 exactly while in PEND, registered, so the IRQ asserts 1 clk after the edge cycle.
REQ-024 SHALL keep PEND if main_snd_on falls before acknowledge; the IRQ stays asserted until acknowledged.
REQ-025 SHALL set sticky overrun and keep PEND on a rising edge while already in PEND; cmd_reg takes the new byte.
REQ-026 SHALL treat a rising edge and an acknowledge in the same cycle while in PEND as follows: move to ACKD, set overrun, load the new byte.
REQ-027 SHALL clear overrun on snd_cen and stat_rd. A simultaneous set wins.
REQ-028 SHALL assert the pending bit exactly while the FSM is in PEND.
REQ-029 SHALL increment the PRESC_W-bit prescaler on each tmr_cen and wrap from all-ones to 0.
REQ-030 SHALL increment the 4-bit timer on the tmr_cen that wraps the prescaler; timer wraps 15 -> 0.
REQ-031 SHALL not affect the timer or the prescaler with any read strobe.

Reset
REQ-032 SHALL on rst place FSM = IDLE, snd_irq_n = 1, cmd_reg = 0, overrun = 0, prescaler = 0, timer = 0, and registered main_snd_on = 0.
REQ-033 SHALL treat main_snd_on held high across reset release as a rising edge in the first active cycle.
REQ-034 SHALL apply reset mid-operation, including in PEND, immediately: snd_irq_n releases asynchronously.

Structure
REQ-035 SHALL keep the FSM state encoding (IDLE=0, PEND=1, ACKD=2) and the stat_dout bit positions as constants in a shared package, jtroc_snd_pkg.
REQ-036 SHALL have one sub-module, jtroc_snd_timer, containing the prescaler and 4-bit timer. Everything else stays flat.
REQ-037 SHALL register all outputs and have no combinational path from any input to any output.

Verification
REQ-038 SHALL cover basic command: latch = 8'h5A, raise snd_on -> snd_irq_n low 1 clk later, cmd_dout = 8'h5A, stat_dout = 8'h03.
REQ-039 SHALL cover acknowledge: int_ack with snd_cen while in PEND -> snd_irq_n high next clk; snd_on low -> FSM IDLE, stat_dout = 8'h00.
REQ-040 SHALL cover overrun: 8'h11 edge, then 8'h22 edge before ack -> cmd_dout = 8'h22, stat_dout bit2 = 1; stat_rd -> bit2 = 0.
REQ-041 SHALL cover simultaneous edge and ack in PEND -> ACKD, overrun = 1, cmd_dout holds the new byte, snd_irq_n high.
REQ-042 SHALL cover the timer: 1024 x 16 tmr_cen pulses with PRESC_W = 10 -> tmr_dout steps 0..15 and returns to 8'h00. Each step follows exactly 1024 pulses.
REQ-043 SHALL cover reset in PEND: rst pulse -> snd_irq_n = 1 and cmd_dout = 8'h00 asynchronously. snd_on held high -> new IRQ after release.
